parc_core_reorder_buffer: RTL

- In-order retirement buffer directly downstream of the PARC scoreboard.
- Allocates one ROB slot per issued destination-writing instruction. Supplies rob_alloc_slot and rob_alloc_slot_spec to the scoreboard.
- Captures writeback results and serves the scoreboard's bypass mux input 5 by slot.
- Retires entries in program order, driving rob_commit_wen/rob_commit_slot back to the scoreboard and the write port to the register file.

---
 rtl/parc_core_rob_pkg.sv | 13 +
 rtl/parc_core_rob_data_array.sv | 23 ++
 rtl/parc_core_reorder_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/parc_core_rob_pkg.sv
// parc_core_rob_pkg: shared sizes and per-entry control state for the reorder buffer
package parc_core_rob_pkg;
  localparam int ROB_ENTRIES = 16;
  localparam int ROB_SLOT_W = 4;
  localparam int ROB_DATA_W = 32;
  typedef struct packed {
    logic       valid;
    logic       pending;
    logic       spec;
    logic       squashed;
    logic [4:0] preg;
  } rob_entry_t;
endpackage

// File: rtl/parc_core_rob_data_array.sv
// parc_core_rob_data_array: result storage with one fill write port and three combinational read ports
module parc_core_rob_data_array #(
  parameter int ENTRIES = 16,
  parameter int SLOT_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [SLOT_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SLOT_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [SLOT_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [SLOT_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [ENTRIES];
  always_ff @(posedge clk) if (wen) mem[waddr] <= wdata;
  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/parc_core_reorder_buffer.sv
// parc_core_reorder_buffer: in-order retirement buffer with speculative entry resolve and slot bypass reads
module parc_core_reorder_buffer
  import parc_core_rob_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int SLOT_W = ROB_SLOT_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc_val,
  input  logic [4:0]        alloc_preg,
  input  logic              alloc_spec_val,
  input  logic [4:0]        alloc_spec_preg,
  output logic              alloc_rdy,
  output logic [SLOT_W-1:0] rob_alloc_slot,
  output logic [SLOT_W-1:0] rob_alloc_slot_spec,
  input  logic              fill_val,
  input  logic [SLOT_W-1:0] fill_slot,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              spec_resolve_val,
  input  logic              spec_resolve_squash,
  input  logic [SLOT_W-1:0] src0_byp_rob_slot,
  output logic [DATA_W-1:0] src0_byp_rob_data,
  input  logic [SLOT_W-1:0] src1_byp_rob_slot,
  output logic [DATA_W-1:0] src1_byp_rob_data,
  output logic              rob_commit_wen,
  output logic [SLOT_W-1:0] rob_commit_slot,
  output logic [4:0]        rob_commit_waddr,
  output logic [DATA_W-1:0] rob_commit_wdata
);
  localparam logic [SLOT_W-1:0] ONE = SLOT_W'(1);
  rob_entry_t ent [ENTRIES];
  rob_entry_t ent_nx [ENTRIES];
  logic [SLOT_W-1:0] head, tail;
  logic [SLOT_W:0] count, n_alloc;
  logic commit;
  logic [DATA_W-1:0] head_data;
  parc_core_rob_data_array #(.ENTRIES(ENTRIES), .SLOT_W(SLOT_W), .DATA_W(DATA_W)) u_data (
    .clk    (clk),
    .wen    (fill_val),
    .waddr  (fill_slot),
    .wdata  (fill_data),
    .raddr0 (src0_byp_rob_slot),
    .rdata0 (src0_byp_rob_data),
    .raddr1 (src1_byp_rob_slot),
    .rdata1 (src1_byp_rob_data),
    .raddr2 (head),
    .rdata2 (head_data)
  );
  // The speculative instruction is older, so it takes tail and the Dhl one follows it.
  always_comb begin
    n_alloc = (SLOT_W+1)'(alloc_val) + (SLOT_W+1)'(alloc_spec_val);
    alloc_rdy = count <= (SLOT_W+1)'(ENTRIES - 2);
    rob_alloc_slot_spec = tail;
    rob_alloc_slot = alloc_spec_val ? tail + ONE : tail;
    commit = ent[head].valid && !ent[head].pending && !ent[head].spec;
    rob_commit_wen = commit && !ent[head].squashed;
    rob_commit_slot = head;
    rob_commit_waddr = ent[head].preg;
    rob_commit_wdata = head_data;
  end
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_nx[i] = ent[i];
      if (spec_resolve_val && ent[i].valid && ent[i].spec) begin
        ent_nx[i].spec = 1'b0;
        ent_nx[i].squashed = spec_resolve_squash;
        ent_nx[i].pending = spec_resolve_squash ? 1'b0 : ent[i].pending;
      end
      if (fill_val && fill_slot == SLOT_W'(i)) ent_nx[i].pending = 1'b0;
      if (commit && head == SLOT_W'(i)) ent_nx[i].valid = 1'b0;
      if (alloc_spec_val && tail == SLOT_W'(i))
        ent_nx[i] = '{valid: 1'b1, pending: 1'b1, spec: 1'b1, squashed: 1'b0, preg: alloc_spec_preg};
      if (alloc_val && rob_alloc_slot == SLOT_W'(i))
        ent_nx[i] = '{valid: 1'b1, pending: 1'b1, spec: 1'b0, squashed: 1'b0, preg: alloc_preg};
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ent <= '{default: '0};
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      ent <= ent_nx;
      head <= commit ? head + ONE : head;
      tail <= tail + n_alloc[SLOT_W-1:0];
      count <= count + n_alloc - (SLOT_W+1)'(commit);
      assert (!((alloc_val || alloc_spec_val) && !alloc_rdy));
      assert (!fill_val || ent[fill_slot].valid);
    end
  end
endmodule
